// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the multicycle RV64 control unit: FSM state
// encoding, major opcodes, branch funct3 codes, ALU operation codes and
// datapath mux-select encodings, plus the funct3/funct7 -> ALU op decoder.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH_WAIT,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_ADDR,
        S_MEM_RD_WAIT,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_LUI,
        S_JAL,
        S_JALR,
        S_TRAP
    } state_t;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // ALU operation codes (0 = idle)
    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;
    localparam logic [2:0] ALU_SLT  = 3'd6;

    // ALU input A select
    localparam logic [1:0] MUX_A_PC     = 2'b00;
    localparam logic [1:0] MUX_A_REG    = 2'b01;
    localparam logic [1:0] MUX_A_PC_OLD = 2'b10;

    // ALU input B select
    localparam logic [1:0] MUX_B_REG    = 2'b00;
    localparam logic [1:0] MUX_B_FOUR   = 2'b01;
    localparam logic [1:0] MUX_B_IMM    = 2'b10;
    localparam logic [1:0] MUX_B_IMM_SH = 2'b11;

    // Register-file write data select
    localparam logic [1:0] DATA_ALU = 2'b00;
    localparam logic [1:0] DATA_MDR = 2'b01;
    localparam logic [1:0] DATA_PC  = 2'b10;
    localparam logic [1:0] DATA_IMM = 2'b11;

    // funct3 (and funct7 bit 5 for register ops) -> ALU op.
    // sub_sel must be 0 for immediate ops, where funct7 is not an opcode field.
    // Unsupported funct3 values fall back to add.
    function automatic logic [2:0] alu_op_decode(input logic [2:0] funct3,
                                                 input logic       sub_sel);
        logic [2:0] op;
        case (funct3)
            3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// wait_counter
// 4-bit down counter used to hold the FSM in a memory wait state.
// Loading sets it to WAIT_CYCLES-1 (0 when WAIT_CYCLES is 0), so a wait
// state lasts WAIT_CYCLES cycles (at least one). Decrement saturates at 0.
// Ports:
//   clk   in  clock, rising edge
//   srst  in  synchronous reset, active-high (clears the count)
//   load  in  load WAIT_CYCLES-1 (takes priority over dec)
//   dec   in  decrement by one, never below 0
//   done  out count is 0 (last cycle of the wait)
module wait_counter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam logic [3:0] LOAD_VAL = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (dec && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 4'd0);

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit
// Multicycle RV64 control FSM: fetch/decode/execute/memory/writeback for
// R-type, I-type ALU, ld, sd, beq/bne/blt/bge, lui, jal and jalr, with
// WAIT_CYCLES memory wait states before fetch and load data.
// Optional feature macro: CTRL_TRAP_EN -- illegal opcodes enter a sticky
// TRAP state and a TRAP output is added; otherwise they act as a NOP.
// Ports:
//   CLK, RST (sync, active-high)        clock / reset
//   INSTRUCAO[31:0]                     instruction register contents
//   ZERO_ALU, MENOR_ALU                 ALU flags (result==0, signed A<B)
//   WR_BANCO_REG, SELECT_MUX_DATA[1:0]  register-file write enable / data source
//   wrDataMemReg, WR_ALU_OUT            MDR / ALUOut load enables
//   wrDataMem                           data-memory write enable
//   reset_wire                          datapath reset pulse
//   operacao[ALU_OP_W-1:0]              ALU operation
//   WRITE_PC, PC_SRC                    PC load enable / source
//   LOAD_IR, WR_MEM_INSTR               IR load enable / instr-mem write (0)
//   SELETOR_MUX_A/B[1:0]                ALU operand selects
//   TRAP (only with CTRL_TRAP_EN)       high while trapped
module multicycle_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         INSTRUCAO,
    input  logic                ZERO_ALU,
    input  logic                MENOR_ALU,
    output logic                WR_BANCO_REG,
    output logic [1:0]          SELECT_MUX_DATA,
    output logic                wrDataMemReg,
    output logic                WR_ALU_OUT,
    output logic                wrDataMem,
    output logic                reset_wire,
    output logic [ALU_OP_W-1:0] operacao,
    output logic                WRITE_PC,
    output logic                PC_SRC,
    output logic                LOAD_IR,
    output logic                WR_MEM_INSTR,
    output logic [1:0]          SELETOR_MUX_A,
    output logic [1:0]          SELETOR_MUX_B
`ifdef CTRL_TRAP_EN
    ,
    output logic                TRAP
`endif
);

    // With no wait states FETCH_WAIT is bypassed entirely.
    localparam state_t FETCH_ENTRY = (WAIT_CYCLES == 0) ? S_FETCH : S_FETCH_WAIT;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] alu_op;
    logic       wait_load;
    logic       wait_dec;
    logic       wait_done;

    logic [6:0] opcode;
    logic [2:0] funct3;
    assign opcode = INSTRUCAO[6:0];
    assign funct3 = INSTRUCAO[14:12];

    // Register indices and most immediate bits belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{INSTRUCAO[31], INSTRUCAO[29:15], INSTRUCAO[11:7]};

    // Reload the counter whenever a wait state is entered from elsewhere.
    assign wait_load = ((state_d == S_FETCH_WAIT) || (state_d == S_MEM_RD_WAIT))
                       && (state_d != state_q);
    assign wait_dec  = (state_q == S_FETCH_WAIT) || (state_q == S_MEM_RD_WAIT);

    wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk  (CLK),
        .srst (RST),
        .load (wait_load),
        .dec  (wait_dec),
        .done (wait_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        WR_BANCO_REG    = 1'b0;
        SELECT_MUX_DATA = DATA_ALU;
        wrDataMemReg    = 1'b0;
        WR_ALU_OUT      = 1'b0;
        wrDataMem       = 1'b0;
        reset_wire      = 1'b0;
        alu_op          = ALU_NONE;
        WRITE_PC        = 1'b0;
        PC_SRC          = 1'b0;
        LOAD_IR         = 1'b0;
        WR_MEM_INSTR    = 1'b0;
        SELETOR_MUX_A   = MUX_A_PC;
        SELETOR_MUX_B   = MUX_B_REG;

        case (state_q)
            S_RESET: begin
                reset_wire = 1'b1;
                state_d    = FETCH_ENTRY;
            end
            S_FETCH_WAIT: begin
                if (wait_done) state_d = S_FETCH;
            end
            S_FETCH: begin
                LOAD_IR       = 1'b1;
                SELETOR_MUX_A = MUX_A_PC;
                SELETOR_MUX_B = MUX_B_FOUR;
                alu_op        = ALU_ADD;
                WRITE_PC      = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                // Precompute PC_OLD + (imm<<1) into ALUOut for branch/jal.
                SELETOR_MUX_A = MUX_A_PC_OLD;
                SELETOR_MUX_B = MUX_B_IMM_SH;
                alu_op        = ALU_ADD;
                WR_ALU_OUT    = 1'b1;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I_ALU:           state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_LUI:             state_d = S_LUI;
                    OP_JAL:             state_d = S_JAL;
                    OP_JALR:            state_d = S_JALR;
`ifdef CTRL_TRAP_EN
                    default:            state_d = S_TRAP;
`else
                    default:            state_d = FETCH_ENTRY;
`endif
                endcase
            end
            S_EXEC_R: begin
                SELETOR_MUX_A = MUX_A_REG;
                SELETOR_MUX_B = MUX_B_REG;
                alu_op        = alu_op_decode(funct3, INSTRUCAO[30]);
                WR_ALU_OUT    = 1'b1;
                state_d       = S_WB_ALU;
            end
            S_EXEC_I: begin
                SELETOR_MUX_A = MUX_A_REG;
                SELETOR_MUX_B = MUX_B_IMM;
                alu_op        = alu_op_decode(funct3, 1'b0);
                WR_ALU_OUT    = 1'b1;
                state_d       = S_WB_ALU;
            end
            S_WB_ALU: begin
                WR_BANCO_REG    = 1'b1;
                SELECT_MUX_DATA = DATA_ALU;
                state_d         = FETCH_ENTRY;
            end
            S_ADDR: begin
                SELETOR_MUX_A = MUX_A_REG;
                SELETOR_MUX_B = MUX_B_IMM;
                alu_op        = ALU_ADD;
                WR_ALU_OUT    = 1'b1;
                state_d       = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD_WAIT;
            end
            S_MEM_RD_WAIT: begin
                // Load data is valid on the final wait cycle only.
                if (wait_done) begin
                    wrDataMemReg = 1'b1;
                    state_d      = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                WR_BANCO_REG    = 1'b1;
                SELECT_MUX_DATA = DATA_MDR;
                state_d         = FETCH_ENTRY;
            end
            S_MEM_WR: begin
                wrDataMem = 1'b1;
                state_d   = FETCH_ENTRY;
            end
            S_BRANCH: begin
                SELETOR_MUX_A = MUX_A_REG;
                SELETOR_MUX_B = MUX_B_REG;
                alu_op        = ALU_SUB;
                case (funct3)
                    F3_BEQ:  WRITE_PC = ZERO_ALU;
                    F3_BNE:  WRITE_PC = ~ZERO_ALU;
                    F3_BLT:  WRITE_PC = MENOR_ALU;
                    F3_BGE:  WRITE_PC = ~MENOR_ALU;
                    default: WRITE_PC = 1'b0;
                endcase
                PC_SRC  = WRITE_PC;
                state_d = FETCH_ENTRY;
            end
            S_LUI: begin
                WR_BANCO_REG    = 1'b1;
                SELECT_MUX_DATA = DATA_IMM;
                state_d         = FETCH_ENTRY;
            end
            S_JAL: begin
                WR_BANCO_REG    = 1'b1;
                SELECT_MUX_DATA = DATA_PC;
                WRITE_PC        = 1'b1;
                PC_SRC          = 1'b1;
                state_d         = FETCH_ENTRY;
            end
            S_JALR: begin
                WR_BANCO_REG    = 1'b1;
                SELECT_MUX_DATA = DATA_PC;
                SELETOR_MUX_A   = MUX_A_REG;
                SELETOR_MUX_B   = MUX_B_IMM;
                alu_op          = ALU_ADD;
                WRITE_PC        = 1'b1;
                PC_SRC          = 1'b0;
                state_d         = FETCH_ENTRY;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign operacao = ALU_OP_W'(alu_op);

`ifdef CTRL_TRAP_EN
    assign TRAP = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb_multicycle_ctrl_unit
// Runs two instances (WAIT_CYCLES=2 and WAIT_CYCLES=0) through directed and
// random instruction streams. A reference model turns each instruction into
// the list of per-cycle control words it should produce; every cycle's
// outputs are compared against that list. Honours CTRL_TRAP_EN if defined.
module tb_multicycle_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero_f;
    logic        menor_f;

    always #5 clk = ~clk;

    // Outputs of the W=2 instance (_a) and the W=0 instance (_b)
    logic       wb_a, mdr_a, alo_a, dmw_a, rw_a, wpc_a, pcs_a, lir_a, wmi_a;
    logic [1:0] data_a, ma_a, mb_a;
    logic [2:0] op_a;
    logic       wb_b, mdr_b, alo_b, dmw_b, rw_b, wpc_b, pcs_b, lir_b, wmi_b;
    logic [1:0] data_b, ma_b, mb_b;
    logic [2:0] op_b;
    logic       trap_a, trap_b;

`ifdef CTRL_TRAP_EN
    logic trap_port_a, trap_port_b;
    assign trap_a = trap_port_a;
    assign trap_b = trap_port_b;
`else
    assign trap_a = 1'b0;
    assign trap_b = 1'b0;
`endif

    multicycle_ctrl_unit #(.ALU_OP_W(3), .WAIT_CYCLES(2)) dut_a (
        .CLK(clk), .RST(rst), .INSTRUCAO(instr), .ZERO_ALU(zero_f), .MENOR_ALU(menor_f),
        .WR_BANCO_REG(wb_a), .SELECT_MUX_DATA(data_a), .wrDataMemReg(mdr_a),
        .WR_ALU_OUT(alo_a), .wrDataMem(dmw_a), .reset_wire(rw_a), .operacao(op_a),
        .WRITE_PC(wpc_a), .PC_SRC(pcs_a), .LOAD_IR(lir_a), .WR_MEM_INSTR(wmi_a),
        .SELETOR_MUX_A(ma_a), .SELETOR_MUX_B(mb_a)
`ifdef CTRL_TRAP_EN
        , .TRAP(trap_port_a)
`endif
    );

    multicycle_ctrl_unit #(.ALU_OP_W(3), .WAIT_CYCLES(0)) dut_b (
        .CLK(clk), .RST(rst), .INSTRUCAO(instr), .ZERO_ALU(zero_f), .MENOR_ALU(menor_f),
        .WR_BANCO_REG(wb_b), .SELECT_MUX_DATA(data_b), .wrDataMemReg(mdr_b),
        .WR_ALU_OUT(alo_b), .wrDataMem(dmw_b), .reset_wire(rw_b), .operacao(op_b),
        .WRITE_PC(wpc_b), .PC_SRC(pcs_b), .LOAD_IR(lir_b), .WR_MEM_INSTR(wmi_b),
        .SELETOR_MUX_A(ma_b), .SELETOR_MUX_B(mb_b)
`ifdef CTRL_TRAP_EN
        , .TRAP(trap_port_b)
`endif
    );

    // Control word layout: {trap, wb, data[1:0], mdr, aluout, dmw, rstw,
    //                       op[2:0], wpc, pcs, lir, wmi, muxa[1:0], muxb[1:0]}
    logic [18:0] obs_a, obs_b;
    assign obs_a = {trap_a, wb_a, data_a, mdr_a, alo_a, dmw_a, rw_a, op_a,
                    wpc_a, pcs_a, lir_a, wmi_a, ma_a, mb_a};
    assign obs_b = {trap_b, wb_b, data_b, mdr_b, alo_b, dmw_b, rw_b, op_b,
                    wpc_b, pcs_b, lir_b, wmi_b, ma_b, mb_b};

    int          n_chk = 0;
    int          n_bad = 0;
    int          cur_w = 2;
    logic [18:0] exp_q[$];

    localparam logic [18:0] IDLE_W  = 19'd0;
    localparam logic [18:0] TRAP_W  = 19'h40000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] cur_obs();
        return (cur_w == 2) ? obs_a : obs_b;
    endfunction

    function automatic logic [18:0] mk(input logic wb, input logic [1:0] data,
                                       input logic mdr, input logic alo, input logic dmw,
                                       input logic rstw, input logic [2:0] op,
                                       input logic wpc, input logic pcs, input logic lir,
                                       input logic [1:0] ma, input logic [1:0] mb);
        return {1'b0, wb, data, mdr, alo, dmw, rstw, op, wpc, pcs, lir, 1'b0, ma, mb};
    endfunction

    function automatic bit is_legal(input logic [6:0] opc);
        return opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111};
    endfunction

    // ALU op table: add 1, sub 2, and 3, or 4, xor 5, slt 6
    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic is_sub);
        case (f3)
            3'b000:  return is_sub ? 3'd2 : 3'd1;
            3'b010:  return 3'd6;
            3'b100:  return 3'd5;
            3'b110:  return 3'd4;
            3'b111:  return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

    // Expected per-cycle words for one instruction, starting at its first
    // fetch-wait cycle (or FETCH when there are no wait states).
    task automatic build(input logic [31:0] ins, input logic z, input logic m, input int w);
        logic [6:0] opc;
        logic [2:0] f3;
        logic       taken;
        opc = ins[6:0];
        f3  = ins[14:12];
        exp_q.delete();
        for (int i = 0; i < w; i++) exp_q.push_back(IDLE_W);
        exp_q.push_back(mk(0, 2'd0, 0, 0, 0, 0, 3'd1, 1, 0, 1, 2'b00, 2'b01));   // FETCH
        exp_q.push_back(mk(0, 2'd0, 0, 1, 0, 0, 3'd1, 0, 0, 0, 2'b10, 2'b11));   // DECODE
        case (opc)
            7'b0110011: begin
                exp_q.push_back(mk(0, 2'd0, 0, 1, 0, 0, ref_alu(f3, ins[30]), 0, 0, 0, 2'b01, 2'b00));
                exp_q.push_back(mk(1, 2'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 2'b00));
            end
            7'b0010011: begin
                exp_q.push_back(mk(0, 2'd0, 0, 1, 0, 0, ref_alu(f3, 1'b0), 0, 0, 0, 2'b01, 2'b10));
                exp_q.push_back(mk(1, 2'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 2'b00));
            end
            7'b0000011: begin
                exp_q.push_back(mk(0, 2'd0, 0, 1, 0, 0, 3'd1, 0, 0, 0, 2'b01, 2'b10));
                for (int i = 1; i < ((w > 0) ? w : 1); i++) exp_q.push_back(IDLE_W);
                exp_q.push_back(mk(0, 2'd0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 2'b00));
                exp_q.push_back(mk(1, 2'd1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 2'b00));
            end
            7'b0100011: begin
                exp_q.push_back(mk(0, 2'd0, 0, 1, 0, 0, 3'd1, 0, 0, 0, 2'b01, 2'b10));
                exp_q.push_back(mk(0, 2'd0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'b00, 2'b00));
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  taken = z;
                    3'b001:  taken = !z;
                    3'b100:  taken = m;
                    3'b101:  taken = !m;
                    default: taken = 1'b0;
                endcase
                exp_q.push_back(mk(0, 2'd0, 0, 0, 0, 0, 3'd2, taken, taken, 0, 2'b01, 2'b00));
            end
            7'b0110111: exp_q.push_back(mk(1, 2'd3, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 2'b00));
            7'b1101111: exp_q.push_back(mk(1, 2'd2, 0, 0, 0, 0, 3'd0, 1, 1, 0, 2'b00, 2'b00));
            7'b1100111: exp_q.push_back(mk(1, 2'd2, 0, 0, 0, 0, 3'd1, 1, 0, 0, 2'b01, 2'b10));
            default: begin
`ifdef CTRL_TRAP_EN
                for (int i = 0; i < 3; i++) exp_q.push_back(TRAP_W);
`endif
            end
        endcase
    endtask

    // Drives one instruction and checks its cycles; abort_at < 0 runs to the end.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic z,
                             input logic m, input int abort_at);
        int n;
        instr   = ins;
        zero_f  = z;
        menor_f = m;
        build(ins, z, m, cur_w);
        n = (abort_at >= 0 && abort_at < exp_q.size()) ? abort_at : exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s.c%0d", tag, i), 32'(cur_obs()), 32'(exp_q[i]));
            @(posedge clk);
            #1;
        end
        $display("W=%0d %s instr=%h z=%0d m=%0d cycles=%0d", cur_w, tag, ins, z, m, n);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk({tag, ".reset"}, 32'(cur_obs()),
            32'(mk(0, 2'd0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 2'b00, 2'b00)));
        @(posedge clk);
        #1;
        $display("W=%0d %s reset pulse", cur_w, tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          k;
        ins = $urandom;
`ifdef CTRL_TRAP_EN
        k = $urandom_range(0, 7);
`else
        k = $urandom_range(0, 8);
`endif
        case (k)
            0: begin
                ins[6:0]   = 7'b0110011;
                ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            1: ins[6:0] = 7'b0010011;
            2: begin ins[6:0] = 7'b0000011; ins[14:12] = 3'b011; end
            3: begin ins[6:0] = 7'b0100011; ins[14:12] = 3'b011; end
            4: ins[6:0] = 7'b1100011;
            5: ins[6:0] = 7'b0110111;
            6: ins[6:0] = 7'b1101111;
            7: ins[6:0] = 7'b1100111;
            default: begin
                while (is_legal(ins[6:0])) ins[6:0] = 7'($urandom);
            end
        endcase
        return ins;
    endfunction

    initial begin
        rst     = 1'b1;
        instr   = 32'h0;
        zero_f  = 1'b0;
        menor_f = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---- WAIT_CYCLES = 2 ----
        cur_w = 2;
        do_reset("w2");
        run_instr("add",  32'h002081B3, 1'b0, 1'b0, -1);   // add x3,x1,x2
        run_instr("sub",  32'h402081B3, 1'b0, 1'b0, -1);   // sub x3,x1,x2
        run_instr("ld",   32'h0000B183, 1'b0, 1'b0, -1);   // ld x3,0(x1)
        run_instr("sd",   32'h0030B023, 1'b0, 1'b0, -1);   // sd x3,0(x1)
        run_instr("beq",  32'h00208463, 1'b1, 1'b0, -1);   // beq taken
        run_instr("bge",  32'h0020D463, 1'b0, 1'b1, -1);   // bge not taken
        run_instr("bx",   32'h0020A463, 1'b1, 1'b1, -1);   // unknown funct3
        run_instr("lui",  32'h123451B7, 1'b0, 1'b0, -1);
        run_instr("jal",  32'h008000EF, 1'b0, 1'b0, -1);
        run_instr("jalr", 32'h000080E7, 1'b0, 1'b0, -1);
        // Reset in the middle of a load: abort after ADDR, inside MEM_RD_WAIT
        run_instr("ld_abort", 32'h0000B183, 1'b0, 1'b0, 5);
        do_reset("mid_ld");
        for (int i = 0; i < 40; i++) begin
            run_instr($sformatf("rnd%0d", i), rand_instr(), 1'($urandom), 1'($urandom), -1);
        end
        // Illegal opcode: NOP in the default build, sticky TRAP otherwise
        run_instr("illegal", 32'h00000000, 1'b0, 1'b0, -1);
        do_reset("post_illegal");
        run_instr("addi", 32'h00508093, 1'b0, 1'b0, -1);

        // ---- WAIT_CYCLES = 0 ----
        cur_w = 0;
        do_reset("w0");
        run_instr("jal0", 32'h008000EF, 1'b0, 1'b0, -1);
        run_instr("ld0",  32'h0000B183, 1'b0, 1'b0, -1);
        run_instr("bne0", 32'h00209463, 1'b0, 1'b0, -1);
        for (int i = 0; i < 40; i++) begin
            run_instr($sformatf("rnd0_%0d", i), rand_instr(), 1'($urandom), 1'($urandom), -1);
        end
        run_instr("illegal0", 32'h0000007F, 1'b0, 1'b0, -1);
        do_reset("w0_end");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
